// File: rtl/ss_display_if.sv
// Bus between a value producer and the seven-segment scan driver: data and
// load strobe in, commit status and active-low display pins out.
interface ss_display_if #(
    parameter int N_DIGITS = 8
) ();
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   blink_en;
    logic                  load;
    logic                  update_pending;
    logic                  frame_tick;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;

    modport master (
        output value, dp_in, digit_en, blink_en, load,
        input  update_pending, frame_tick, seg, dp, an
    );

    modport slave (
        input  value, dp_in, digit_en, blink_en, load,
        output update_pending, frame_tick, seg, dp, an
    );
endinterface

// File: rtl/ss_display_mux.sv
// Time-multiplexed N-digit seven-segment driver with blink, decimal point and
// frame-synchronous double buffering. Optional: SS_LEADING_ZERO_BLANK_EN.
module ss_display_mux #(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_CNT  = 100000,
    parameter int BLINK_FRAMES = 256
) (
    input  logic       clk,
    input  logic       rst,
    ss_display_if.slave bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_CNT);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CNT - 1);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]      refresh_cnt_reg, refresh_cnt_next;
    logic [IDX_W-1:0]      digit_idx_reg, digit_idx_next;
    logic [BLK_W-1:0]      frame_cnt_reg, frame_cnt_next;
    logic                  blink_phase_reg, blink_phase_next;
    logic                  frame_tick_reg;
    logic                  slot_end, frame_wrap;

    logic [4*N_DIGITS-1:0] pend_value_reg, pend_value_next;
    logic [N_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
    logic [N_DIGITS-1:0]   pend_en_reg, pend_en_next;
    logic [N_DIGITS-1:0]   pend_blink_reg, pend_blink_next;
    logic [4*N_DIGITS-1:0] act_value_reg, act_value_next;
    logic [N_DIGITS-1:0]   act_dp_reg, act_dp_next;
    logic [N_DIGITS-1:0]   act_en_reg, act_en_next;
    logic [N_DIGITS-1:0]   act_blink_reg, act_blink_next;
    logic                  update_pending_reg, update_pending_next;

    logic [3:0]            act_nib [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_blank;
    logic [N_DIGITS-1:0]   digit_blank;

    logic [N_DIGITS-1:0]   an_reg, an_next;
    logic [6:0]            seg_reg, seg_next;
    logic                  dp_reg, dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign slot_end   = (refresh_cnt_reg == LAST_CNT);
    assign frame_wrap = slot_end && (digit_idx_reg == LAST_IDX);

    always_comb begin
        refresh_cnt_next = slot_end ? '0 : refresh_cnt_reg + CNT_W'(1);
        digit_idx_next   = digit_idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (slot_end) begin
            digit_idx_next = frame_wrap ? '0 : digit_idx_reg + IDX_W'(1);
        end
        if (frame_wrap) begin
            if (frame_cnt_reg == LAST_BLK) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + BLK_W'(1);
            end
        end
    end

    // A load landing on the wrap edge skips the pending set so it shows at once.
    always_comb begin
        pend_value_next     = pend_value_reg;
        pend_dp_next        = pend_dp_reg;
        pend_en_next        = pend_en_reg;
        pend_blink_next     = pend_blink_reg;
        act_value_next      = act_value_reg;
        act_dp_next         = act_dp_reg;
        act_en_next         = act_en_reg;
        act_blink_next      = act_blink_reg;
        update_pending_next = update_pending_reg;
        if (bus.load) begin
            pend_value_next     = bus.value;
            pend_dp_next        = bus.dp_in;
            pend_en_next        = bus.digit_en;
            pend_blink_next     = bus.blink_en;
            update_pending_next = 1'b1;
        end
        if (frame_wrap) begin
            if (bus.load) begin
                act_value_next      = bus.value;
                act_dp_next         = bus.dp_in;
                act_en_next         = bus.digit_en;
                act_blink_next      = bus.blink_en;
                update_pending_next = 1'b0;
            end else if (update_pending_reg) begin
                act_value_next      = pend_value_reg;
                act_dp_next         = pend_dp_reg;
                act_en_next         = pend_en_reg;
                act_blink_next      = pend_blink_reg;
                update_pending_next = 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign act_nib[gi] = act_value_reg[4*gi +: 4];
`ifdef SS_LEADING_ZERO_BLANK_EN
            // Blank a zero digit only when no enabled non-zero digit sits at or above it.
            logic [N_DIGITS-1:0] nz_vec;
            for (genvar gj = 0; gj < N_DIGITS; gj++) begin : g_nz
                assign nz_vec[gj] = (gj >= gi) && act_en_reg[gj]
                                    && (act_value_reg[4*gj +: 4] != 4'h0);
            end
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = (act_nib[gi] == 4'h0) && !(|nz_vec);
            end
`else
            assign lz_blank[gi] = 1'b0;
`endif
            assign digit_blank[gi] = !act_en_reg[gi]
                                     || (blink_phase_reg && act_blink_reg[gi])
                                     || lz_blank[gi];
        end
    endgenerate

    always_comb begin
        an_next  = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx_reg == IDX_W'(i) && !digit_blank[i]) begin
                an_next[i] = 1'b0;
                seg_next   = hex_to_seg(act_nib[i]);
                dp_next    = ~act_dp_reg[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt_reg    <= '0;
            digit_idx_reg      <= '0;
            frame_cnt_reg      <= '0;
            blink_phase_reg    <= 1'b0;
            frame_tick_reg     <= 1'b0;
            pend_value_reg     <= '0;
            pend_dp_reg        <= '0;
            pend_en_reg        <= '0;
            pend_blink_reg     <= '0;
            act_value_reg      <= '0;
            act_dp_reg         <= '0;
            act_en_reg         <= '0;
            act_blink_reg      <= '0;
            update_pending_reg <= 1'b0;
            an_reg             <= '1;
            seg_reg            <= 7'b1111111;
            dp_reg             <= 1'b1;
        end else begin
            refresh_cnt_reg    <= refresh_cnt_next;
            digit_idx_reg      <= digit_idx_next;
            frame_cnt_reg      <= frame_cnt_next;
            blink_phase_reg    <= blink_phase_next;
            frame_tick_reg     <= frame_wrap;
            pend_value_reg     <= pend_value_next;
            pend_dp_reg        <= pend_dp_next;
            pend_en_reg        <= pend_en_next;
            pend_blink_reg     <= pend_blink_next;
            act_value_reg      <= act_value_next;
            act_dp_reg         <= act_dp_next;
            act_en_reg         <= act_en_next;
            act_blink_reg      <= act_blink_next;
            update_pending_reg <= update_pending_next;
            an_reg             <= an_next;
            seg_reg            <= seg_next;
            dp_reg             <= dp_next;
        end
    end

    assign bus.update_pending = update_pending_reg;
    assign bus.frame_tick     = frame_tick_reg;
    assign bus.seg            = seg_reg;
    assign bus.dp             = dp_reg;
    assign bus.an             = an_reg;
endmodule

// File: tb/tb_ss_display_mux.sv
// Directed bench for ss_display_mux: 4-digit main instance plus 1- and 16-digit
// instances for the index-wrap limits; expected slots queued in a scoreboard.
module tb_ss_display_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ss_display_if #(.N_DIGITS(4))  bus4 ();
    ss_display_if #(.N_DIGITS(1))  bus1 ();
    ss_display_if #(.N_DIGITS(16)) bus16 ();

    ss_display_mux #(.N_DIGITS(4), .REFRESH_CNT(4), .BLINK_FRAMES(2)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));
    ss_display_mux #(.N_DIGITS(1), .REFRESH_CNT(2), .BLINK_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    ss_display_mux #(.N_DIGITS(16), .REFRESH_CNT(2), .BLINK_FRAMES(1)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16));

    typedef struct packed {
        logic [15:0] an;
        logic [6:0]  seg;
        logic        dp;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         ticks  = 0;
    logic [6:0] seg_tab [16];
    logic [15:0] sh_val;
    logic [3:0]  sh_en, sh_dp, sh_blk;
    localparam logic [63:0] V16 = 64'h0123456789ABCDEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every wait goes through here so the frame count used for blink phase stays exact.
    task automatic step();
        @(negedge clk);
        if (bus4.frame_tick === 1'b1) ticks++;
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (bus4.frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL frame_tick_timeout observed=0 expected=1");
        end
    endtask

    function automatic exp_t exp_digit(input int i, input int n, input logic [63:0] val,
                                       input logic [15:0] en, input logic [15:0] dpv,
                                       input logic [15:0] blk, input bit phase);
        exp_t        e;
        logic [3:0]  nib;
        logic [15:0] an_full;
        bit          blank;
        bit          nz_above;
        nib      = val[4*i +: 4];
        blank    = !en[i] || (phase && blk[i]);
        nz_above = 1'b0;
        for (int j = i; j < n; j++)
            if (en[j] && val[4*j +: 4] != 4'h0) nz_above = 1'b1;
`ifdef SS_LEADING_ZERO_BLANK_EN
        if (i > 0 && nib == 4'h0 && !nz_above) blank = 1'b1;
`endif
        an_full = 16'((32'd1 << n) - 1);
        if (blank) begin
            e.seg = 7'b1111111;
            e.dp  = 1'b1;
        end else begin
            an_full[i] = 1'b0;
            e.seg      = seg_tab[nib];
            e.dp       = ~dpv[i];
        end
        e.an = an_full;
        return e;
    endfunction

    task automatic push_frame();
        bit phase;
        phase = ((ticks / 2) % 2) == 1;
        for (int i = 0; i < 4; i++)
            sb.push_back(exp_digit(i, 4, {48'd0, sh_val}, {12'd0, sh_en},
                                   {12'd0, sh_dp}, {12'd0, sh_blk}, phase));
    endtask

    // Entered on the cycle frame_tick is seen; ends on the next frame_tick cycle.
    task automatic run_frame(input int load_at, input logic [15:0] ld_val,
                             input logic [3:0] ld_en, input logic [3:0] ld_dp,
                             input logic [3:0] ld_blk);
        exp_t e;
        push_frame();
        for (int c = 1; c <= 16; c++) begin
            if (c - 1 == load_at) begin
                bus4.value    = ld_val;
                bus4.digit_en = ld_en;
                bus4.dp_in    = ld_dp;
                bus4.blink_en = ld_blk;
                bus4.load     = 1'b1;
            end
            step();
            bus4.load = 1'b0;
            if (c % 4 == 2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL scoreboard_empty observed=0 expected=1");
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("an_slot%0d", (c - 2) / 4), {28'd0, bus4.an}, {16'd0, e.an});
                    chk($sformatf("seg_slot%0d", (c - 2) / 4), {25'd0, bus4.seg}, {25'd0, e.seg});
                    chk($sformatf("dp_slot%0d", (c - 2) / 4), {31'd0, bus4.dp}, {31'd0, e.dp});
                end
            end
            if (c == 8)
                chk("pending_mid", {31'd0, bus4.update_pending},
                    {31'd0, (load_at >= 0 && load_at < 7)});
        end
        chk("frame_period", {31'd0, bus4.frame_tick}, 32'd1);
        chk("pending_end", {31'd0, bus4.update_pending}, 32'd0);
        if (load_at >= 0) begin
            sh_val = ld_val; sh_en = ld_en; sh_dp = ld_dp; sh_blk = ld_blk;
        end
    endtask

    initial begin
        exp_t e;
        logic prev_ft;
        bit   found;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        bus4.value = '0;  bus4.dp_in = '0;  bus4.digit_en = '0;  bus4.blink_en = '0;  bus4.load = 1'b0;
        bus1.value = '0;  bus1.dp_in = '0;  bus1.digit_en = '0;  bus1.blink_en = '0;  bus1.load = 1'b0;
        bus16.value = '0; bus16.dp_in = '0; bus16.digit_en = '0; bus16.blink_en = '0; bus16.load = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, bus4.an}, 32'hF);
        chk("rst_seg", {25'd0, bus4.seg}, 32'h7F);
        chk("rst_dp", {31'd0, bus4.dp}, 32'd1);
        chk("rst_pending", {31'd0, bus4.update_pending}, 32'd0);
        chk("rst_frame_tick", {31'd0, bus4.frame_tick}, 32'd0);
        rst = 1'b0;
        ticks = 0;

        for (int i = 0; i < 40; i++) begin
            step();
            chk("dark_no_load", {28'd0, bus4.an}, 32'hF);
        end

        // First load lands mid-frame: pending, still dark until the wrap.
        wait_tick();
        step(); step();
        bus4.value = 16'h12AF; bus4.digit_en = 4'hF; bus4.dp_in = 4'h0; bus4.blink_en = 4'h0;
        bus4.load = 1'b1;
        step();
        bus4.load = 1'b0;
        chk("first_load_pending", {31'd0, bus4.update_pending}, 32'd1);
        chk("first_load_dark", {28'd0, bus4.an}, 32'hF);
        wait_tick();
        chk("first_commit_pending", {31'd0, bus4.update_pending}, 32'd0);
        sh_val = 16'h12AF; sh_en = 4'hF; sh_dp = 4'h0; sh_blk = 4'h0;

        run_frame(-1, 16'h0, 4'h0, 4'h0, 4'h0);
        run_frame(1, 16'h0000, 4'hF, 4'h0, 4'h0);
        run_frame(-1, 16'h0, 4'h0, 4'h0, 4'h0);
        run_frame(15, 16'h12AF, 4'hF, 4'h0, 4'h0);
        run_frame(-1, 16'h0, 4'h0, 4'h0, 4'h0);
`ifdef SS_LEADING_ZERO_BLANK_EN
        run_frame(15, 16'h0042, 4'hF, 4'h0, 4'h0);
        run_frame(15, 16'h0000, 4'hF, 4'h0, 4'h0);
        run_frame(15, 16'h1002, 4'hF, 4'h0, 4'h0);
        run_frame(-1, 16'h0, 4'h0, 4'h0, 4'h0);
`endif
        run_frame(15, 16'h12AF, 4'b1011, 4'b0001, 4'b0001);
        for (int f = 0; f < 4; f++) run_frame(-1, 16'h0, 4'h0, 4'h0, 4'h0);

        // Pending load followed by a mid-scan reset: blank at once, pending lost.
        step(); step(); step();
        bus4.value = 16'h0000; bus4.digit_en = 4'hF; bus4.dp_in = 4'h0; bus4.blink_en = 4'h0;
        bus4.load = 1'b1;
        step();
        bus4.load = 1'b0;
        chk("pre_rst_pending", {31'd0, bus4.update_pending}, 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_an", {28'd0, bus4.an}, 32'hF);
        chk("midrst_seg", {25'd0, bus4.seg}, 32'h7F);
        chk("midrst_dp", {31'd0, bus4.dp}, 32'd1);
        chk("midrst_pending", {31'd0, bus4.update_pending}, 32'd0);
        step();
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            chk("post_rst_dark", {28'd0, bus4.an}, 32'hF);
            chk("post_rst_pending", {31'd0, bus4.update_pending}, 32'd0);
        end

        // Single- and sixteen-digit limits.
        bus1.value = 4'h7; bus1.digit_en = 1'b1; bus1.dp_in = 1'b1; bus1.load = 1'b1;
        bus16.value = V16; bus16.digit_en = 16'hFFFF; bus16.load = 1'b1;
        step();
        bus1.load = 1'b0;
        bus16.load = 1'b0;
        repeat (4) step();
        prev_ft = bus1.frame_tick;
        e = exp_digit(0, 1, 64'h7, 16'h1, 16'h1, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("n1_an", {31'd0, bus1.an}, {31'd0, e.an[0]});
            chk("n1_seg", {25'd0, bus1.seg}, {25'd0, e.seg});
            chk("n1_dp", {31'd0, bus1.dp}, {31'd0, e.dp});
            chk("n1_frame_tick", {31'd0, bus1.frame_tick}, {31'd0, ~prev_ft});
            prev_ft = bus1.frame_tick;
        end

        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (bus16.frame_tick === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL n16_tick_timeout observed=0 expected=1");
        end
        for (int k = 0; k < 16; k++) begin
            step();
            e = exp_digit(k, 16, V16, 16'hFFFF, 16'h0, 16'h0, 1'b0);
            chk($sformatf("n16_an_d%0d", k), {16'd0, bus16.an}, {16'd0, e.an});
            chk($sformatf("n16_seg_d%0d", k), {25'd0, bus16.seg}, {25'd0, e.seg});
            step();
        end
        chk("n16_frame_period", {31'd0, bus16.frame_tick}, 32'd1);
        step();
        chk("n16_wrap_an", {16'd0, bus16.an}, 32'h0000FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ss_display_mux.md
Name: ss_display_mux

Overview:
- Time-multiplexed N-digit seven-segment display driver: scans the digit anodes and converts each hex nibble to segments internally.
- Adds per-digit enable, blink and decimal point, plus tear-free double-buffered updates committed on frame boundaries.
- Sits between datapath/FSM blocks that produce hex/BCD values and the board display pins (active-low segments and anodes).

Parameters:
- N_DIGITS, 8, number of digits scanned; legal range 1..16.
- REFRESH_CNT, 100000, clk cycles each digit is lit; minimum 2.
- BLINK_FRAMES, 256, full scan frames per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- value  input  4*N_DIGITS  hex nibbles; digit i = value[4i+3:4i].
- dp_in  input  N_DIGITS  decimal point request per digit, active-high.
- digit_en  input  N_DIGITS  1 = digit displayed, 0 = blanked.
- blink_en  input  N_DIGITS  1 = digit blinks.
- load  input  1  single-cycle strobe; captures value, dp_in, digit_en and blink_en.
- update_pending  output  1  high while captured data awaits commit.
- frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  N_DIGITS  anodes, active-low, one-hot-low when lit.

Behaviour:
- Reset (async, rst=1):
  - Counters, digit index and blink phase = 0.
  - an = all 1, seg = 7'b1111111, dp = 1, frame_tick = 0, update_pending = 0.
  - Active register set cleared: value 0, digit_en 0, so the display is dark until the first load commits.
- Scan timing:
  - The refresh counter counts 0..REFRESH_CNT-1.
  - At terminal count it returns to 0 and the digit index advances; index N_DIGITS-1 wraps to 0.
  - frame_tick is asserted for the single cycle in which the index becomes 0.
  - With N_DIGITS=1 the index stays 0 and frame_tick pulses every REFRESH_CNT cycles.
- Output timing: an, seg and dp are registered and reflect the current index one clk after the index changes.
- Encoding (hex to seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110
- Lit digit: an[index]=0, all other anode bits = 1, seg = encoding of the active nibble, dp = ~active_dp[index].
- Blanked digit: active digit_en[index]=0, or blink_phase=1 with active blink_en[index]=1. Then an = all 1, seg = 7'b1111111, dp = 1. The scan still spends REFRESH_CNT cycles on the slot, so timing is unchanged.
- Blink: a frame counter counts frame_ticks; blink_phase toggles every BLINK_FRAMES frames.
- Double buffering:
  - load captures the inputs into the pending set and sets update_pending the next cycle.
  - At a frame wrap with update_pending=1, pending is copied to the active set and update_pending clears.
  - Multiple loads before a commit: the last load wins.
- Load coinciding with frame wrap: the inputs go directly to the active set, bypassing pending, and update_pending ends the cycle at 0.
- Mid-frame loads never change the displayed digits before the next wrap.
- Reset mid-operation: immediate blank per the reset values; pending data is discarded.

Optional Feature:
- Macro: SS_LEADING_ZERO_BLANK_EN.
- Defined: each enabled digit above the most significant enabled digit holding a non-zero nibble, whose own nibble is 0, is blanked as if digit_en=0. Digit 0 is never blanked by this rule. The rule is evaluated on the active set.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
- Reset: assert rst mid-scan -> same cycle an=all 1, seg=7'b1111111, dp=1, update_pending=0. After release with no load, the display stays dark indefinitely.
- Scan order (N_DIGITS=4, REFRESH_CNT=4): load value=16'h12AF, digit_en=4'hF -> after the first wrap, an cycles 1110, 1101, 1011, 0111 every 4 clks. seg = 0001110, 0001000, 0100100, 1111001. frame_tick pulses every 16 clks.
- Double buffer: load 16'h0000 two cycles after a wrap -> update_pending=1 for the rest of the frame, old digits remain shown, the new digits appear starting at the next digit-0 slot. Repeat with load exactly on the wrap cycle -> applied immediately, update_pending stays 0.
- Enable/dp/blink (BLINK_FRAMES=2): digit_en=4'b1011, dp_in=4'b0001, blink_en=4'b0001 -> slot 2 an=all 1. Digit 0 shows dp=0 for 2 frames, then is fully blank for 2 frames, alternating.
- Wrap and limits: N_DIGITS=1, REFRESH_CNT=2 -> an toggles never, stays 0 when enabled; frame_tick every 2 clks. N_DIGITS=16 -> index wraps 15 -> 0 correctly.
- With SS_LEADING_ZERO_BLANK_EN (N_DIGITS=4): value 16'h0042 -> digits 3,2 blank, digits 1,0 show 4,2. value 16'h0000 -> only digit 0 shows 0. value 16'h1002 -> all four shown.
